memory: RTL and testbench



---
 rtl/memory_pkg.sv | 19 +
 rtl/memory_addr_decode.sv | 14 +
 rtl/memory.sv | 46 ++++
 tb/tb_memory.sv | 120 ++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// memory_pkg: default geometry and address helpers shared by the RAM and its bench
package memory_pkg;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int OFFSET_BITS_DEF = $clog2(DATA_WIDTH_DEF / 8);
    localparam int DEPTH_DEF = 2 ** (ADDR_WIDTH_DEF - OFFSET_BITS_DEF);

    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic [ADDR_WIDTH_DEF-OFFSET_BITS_DEF-1:0] word_index(input logic [ADDR_WIDTH_DEF-1:0] addr);
        return addr[ADDR_WIDTH_DEF-1:OFFSET_BITS_DEF];
    endfunction

    function automatic logic is_aligned(input logic [ADDR_WIDTH_DEF-1:0] addr);
        return addr[OFFSET_BITS_DEF-1:0] == '0;
    endfunction
endpackage

// File: rtl/memory_addr_decode.sv
// memory_addr_decode: splits a byte address into word index and in-word offset
module memory_addr_decode #(
    parameter int ADDR_WIDTH = 8,
    parameter int OFFSET_BITS = 2
) (
    input  logic [ADDR_WIDTH-1:0]             addr,
    output logic [ADDR_WIDTH-OFFSET_BITS-1:0] index,
    output logic                              aligned
);
    logic [OFFSET_BITS-1:0] offset;
    assign index = addr[ADDR_WIDTH-1:OFFSET_BITS];
    assign offset = addr[OFFSET_BITS-1:0];
    assign aligned = offset == '0;
endmodule

// File: rtl/memory.sv
// memory: word-organised RAM, synchronous write, combinational read, sync active-low reset.
// Define MEMORY_MISALIGN_ERR_EN to add the registered misalign_err flag.
module memory
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out
`ifdef MEMORY_MISALIGN_ERR_EN
    ,
    output logic                  misalign_err
`endif
);
    localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);
    localparam int IW = ADDR_WIDTH - OFFSET_BITS;
    localparam int DEPTH = 2 ** IW;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0] index;
    logic aligned;
    memory_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .OFFSET_BITS(OFFSET_BITS)) u_decode (
        .addr(addr),
        .index(index),
        .aligned(aligned)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (write_enable && aligned) begin
            mem[index] <= data_in;
        end
    end
    // Output is forced to zero while reset is held, not just after the clearing edge
    assign data_out = rst_n ? mem[index] : '0;
`ifdef MEMORY_MISALIGN_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) misalign_err <= 1'b0;
        else if (write_enable) misalign_err <= !aligned;
    end
`endif
endmodule

// File: tb/tb_memory.sv
// tb_memory: directed checks of the word RAM, including misaligned writes and reset priority
module tb_memory;
    import memory_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] data_in = '0;
    logic        write_enable = 1'b0;
    logic [31:0] data_out;
`ifdef MEMORY_MISALIGN_ERR_EN
    logic        misalign_err;
`endif
    int tests = 0;
    int fails = 0;

    memory dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .data_in(data_in),
        .write_enable(write_enable),
        .data_out(data_out)
`ifdef MEMORY_MISALIGN_ERR_EN
        ,
        .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        addr = a;
        #1;
        check(tag, data_out, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr = a;
        data_in = d;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rd_val;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(8'h00, 32'h0, "rst_00");
        rd(8'h04, 32'h0, "rst_04");
        rd(8'h08, 32'h0, "rst_08");
`ifdef MEMORY_MISALIGN_ERR_EN
        check("merr_rst", 32'(misalign_err), 32'h0);
`endif
        wr(8'h00, 32'hDEADBEEF);
        rd(8'h00, 32'hDEADBEEF, "wr_00");
        wr(8'h04, 32'hCAFEBABE);
        wr(8'h08, 32'h12345678);
        rd(8'h04, 32'hCAFEBABE, "wr_04");
        rd(8'h08, 32'h12345678, "wr_08");
        rd(8'h00, 32'hDEADBEEF, "keep_00");
        rd(8'h0B, 32'h12345678, "offset_ignored");
        wr(8'h02, 32'h11111111);
        rd(8'h00, 32'hDEADBEEF, "mis_00");
        rd(8'h04, 32'hCAFEBABE, "mis_04");
`ifdef MEMORY_MISALIGN_ERR_EN
        check("merr_set", 32'(misalign_err), 32'(!is_aligned(8'h02)));
        @(posedge clk);
        #1;
        check("merr_hold", 32'(misalign_err), 32'h1);
`endif
        addr = 8'h04;
        data_in = 32'h22222222;
        write_enable = 1'b1;
        #1;
        check("old_during_wr", data_out, 32'hCAFEBABE);
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        rd(8'h04, 32'h22222222, "overwrite_04");
`ifdef MEMORY_MISALIGN_ERR_EN
        check("merr_clr", 32'(misalign_err), 32'h0);
`endif
        wr(8'hFC, 32'hA5A5F00D);
        rd(8'hFF, 32'hA5A5F00D, "top_word");
        addr = 8'h04;
        data_in = 32'h33333333;
        write_enable = 1'b1;
        rst_n = 1'b0;
        #1;
        check("out_in_rst", data_out, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        write_enable = 1'b0;
        rd(8'h00, 32'h0, "rstwr_00");
        rd(8'h04, 32'h0, "rstwr_04");
        rd(8'h08, 32'h0, "rstwr_08");
        rd(8'hFC, 32'h0, "rstwr_FC");
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom_range(0, 63) << 2);
            rd_val = $urandom;
            wr(ra, rd_val);
            rd(ra, rd_val, "rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
